fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction queue between fetch and decode.
- Buffers each fetched instruction together with its PC and branch-prediction metadata, so a decode stall does not stall the I-cache read.
- Discards all contents on an execute-stage redirect (mispredict). Also discards the single in-flight fetch response that was issued before the redirect.
- Applies backpressure to fetch through enq_ready.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enq_valid  in  1  fetch presents a returned instruction this cycle.
- enq_ready  out  1  queue accepts enq this cycle.
- enq_pc  in  32  PC of the instruction.
- enq_instr  in  32  instruction word (rdata from I-side).
- enq_predict  in  39  predict_regs {taken, bhr[5:0], btb_address[31:0]}.
- fetch_outstanding  in  1  fetch has an I-cache read issued but not yet returned.
- flush  in  1  execute redirect; kills all queued and in-flight instructions.
- deq_valid  out  1  head entry valid for decode.
- deq_ready  in  1  decode consumes head this cycle.
- deq_pc  out  32  head PC.
- deq_instr  out  32  head instruction.
- deq_predict  out  39  head predict_regs.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, reset_n=0):
  - head=tail=0, count=0, state=RUN.
  - All storage entries are zeroed, so deq_pc, deq_instr and deq_predict read 0.
  - deq_valid=0, enq_ready=1.
- Storage: circular buffer of DEPTH entries {pc, instr, predict}, written at tail and read at head. Pointers wrap modulo DEPTH.
- Handshake:
  - enq_fire = enq_valid & enq_ready & (state==RUN) & !flush.
  - deq_fire = deq_valid & deq_ready.
- enq_ready = (count != DEPTH). It is registered-derived with no combinational path from deq_ready. When full, enq is refused even if deq fires the same cycle.
- deq_valid = (count != 0) & !flush. deq_* are driven combinationally from storage[head].
- Latency: an entry enqueued in cycle N is visible at deq in cycle N+1. There is no empty bypass.
- Simultaneous enq_fire and deq_fire: count is unchanged and both pointers advance.
- Flush (highest priority):
  - At the next edge, head=tail=0 and count=0.
  - A same-cycle enq is dropped. A same-cycle deq is not counted, because deq_valid is already 0.
- Drop FSM:
  - RUN: normal operation.
  - DROP: the next enq_valid beat is stale. It is discarded and the FSM returns to RUN. enq_ready stays as computed, so fetch sees the beat as accepted.
  - RUN→DROP on flush & fetch_outstanding & !enq_valid.
  - RUN stays RUN on flush & enq_valid, because the stale beat is killed this cycle.
  - DROP→RUN on enq_valid & !flush.
  - DROP stays DROP on flush, whatever enq_valid is.
  - Nothing is written to storage while in DROP.
- Reset asserted mid-operation: all state is cleared immediately, including DROP→RUN.
- count arithmetic is PTR_W+1 bits wide. It must never exceed DEPTH or underflow; the bench asserts both.

Decomposition:
- rv32i_types gains:
  - `fetch_entry` packed struct {pc, instr, predict_regs}.
  - `fq_state_t` enum {FQ_RUN, FQ_DROP}.
- predict_regs is reused unchanged.
- One natural sub-module, fetch_queue_ram: DEPTH × $bits(fetch_entry) register array with one write port, one async read port, and async clear. The pointers and FSM stay in fetch_queue.

Test Plan:
- Fill and drain:
  - Stimulus: deq_ready=0; enq PCs 0x00,0x04,0x08,0x0C.
  - Response: count 1,2,3,4; enq_ready=0 after the 4th; a 5th enq_valid is not accepted.
  - Then deq_ready=1: deq_pc 0x00,0x04,0x08,0x0C on consecutive cycles, then deq_valid=0.
- Streaming:
  - Stimulus: enq and deq every cycle with PCs 0x100+4k for 12 cycles.
  - Response: count holds at 1; pointers wrap past DEPTH; order is preserved; deq_predict matches the enqueued value.
- Flush with full queue:
  - Stimulus: count=4 and deq_ready=1 in the flush cycle.
  - Response: deq_valid=0 that cycle; count=0 next cycle; the next enq PC 0x200 appears at deq one cycle later.
- Stale response drop:
  - Stimulus: flush with fetch_outstanding=1 and enq_valid=0; next cycle enq_valid with PC 0x40; following cycle enq PC 0x80 (redirect target).
  - Response: 0x40 is never dequeued; 0x80 is the first deq_pc; count never exceeds 1.
- Flush coinciding with a response:
  - Stimulus: flush=1 and enq_valid=1 (PC 0x44) in the same cycle.
  - Response: 0x44 is dropped, state stays RUN, and the next enq (PC 0x90) is accepted.
- Asynchronous reset:
  - Stimulus: reset_n low mid-cycle while in DROP with count=3.
  - Response: immediately count=0, deq_valid=0, deq_pc=0, enq_ready=1, state RUN.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue: branch-prediction
// metadata, the stored queue entry, and the stale-response drop FSM states.
package fetch_queue_pkg;

    typedef struct packed {
        logic        taken;
        logic [5:0]  bhr;
        logic [31:0] btb_address;
    } predict_regs;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        predict_regs predict;
    } fetch_entry;

    typedef enum logic {
        FQ_RUN  = 1'b0,
        FQ_DROP = 1'b1
    } fq_state_t;

    localparam int FQ_PREDICT_W = $bits(predict_regs);
    localparam int FQ_ENTRY_W   = $bits(fetch_entry);

endpackage

// File: rtl/fetch_queue_ram.sv
// Register-array storage for the fetch queue: one synchronous write port,
// one asynchronous read port, and an asynchronous clear of every entry.
module fetch_queue_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  fetch_entry               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output fetch_entry               rd_data
);

    fetch_entry mem [DEPTH];

    // Clearing on reset keeps the head read-out at zero while the queue is empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode; flushes on redirect and drops
// the one stale I-cache response that was still in flight at the redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [31:0]              enq_pc,
    input  logic [31:0]              enq_instr,
    input  logic [38:0]              enq_predict,
    input  logic                     fetch_outstanding,
    input  logic                     flush,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              deq_pc,
    output logic [31:0]              deq_instr,
    output logic [38:0]              deq_predict,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count_q;
    fq_state_t        state;
    fq_state_t        state_next;
    logic             enq_fire;
    logic             deq_fire;
    fetch_entry       wr_entry;
    fetch_entry       rd_entry;

    // enq_ready depends only on registered occupancy, never on deq_ready.
    assign enq_ready = (count_q != FULL_COUNT);
    assign deq_valid = (count_q != '0) && !flush;
    assign enq_fire  = enq_valid && enq_ready && (state == FQ_RUN) && !flush;
    assign deq_fire  = deq_valid && deq_ready;
    assign count     = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PTR_ONE;
            end
            if (deq_fire) begin
                head <= head + PTR_ONE;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_q <= count_q + COUNT_ONE;
                2'b01:   count_q <= count_q - COUNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FQ_RUN;
        end else begin
            state <= state_next;
        end
    end

    // A flush with a read still in flight means the next returned beat is stale;
    // if that beat arrives in the flush cycle itself it is already killed.
    always_comb begin
        state_next = state;
        case (state)
            FQ_RUN: begin
                if (flush && fetch_outstanding && !enq_valid) begin
                    state_next = FQ_DROP;
                end
            end
            FQ_DROP: begin
                if (!flush && enq_valid) begin
                    state_next = FQ_RUN;
                end
            end
            default: state_next = FQ_RUN;
        endcase
    end

    assign wr_entry = {enq_pc, enq_instr, enq_predict};

    fetch_queue_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (enq_fire),
        .wr_addr (tail),
        .wr_data (wr_entry),
        .rd_addr (head),
        .rd_data (rd_entry)
    );

    assign deq_pc      = rd_entry.pc;
    assign deq_instr   = rd_entry.instr;
    assign deq_predict = rd_entry.predict;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written
// flush/drop/reset sequences, and randomized traffic against a queue model.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_pc;
    logic [31:0] enq_instr;
    logic [38:0] enq_predict;
    logic        fetch_outstanding;
    logic        flush;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [38:0] deq_predict;
    logic [2:0]  count;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic        ev;
        logic [31:0] pc;
        logic        dr;
        logic        fl;
        logic        fo;
        logic        exp_ready;
        logic        exp_valid;
        logic [2:0]  exp_count;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [38:0] predict;
    } entry_t;

    vec_t   vecs [10];
    entry_t model_q [$];
    bit     model_drop;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enq_valid         (enq_valid),
        .enq_ready         (enq_ready),
        .enq_pc            (enq_pc),
        .enq_instr         (enq_instr),
        .enq_predict       (enq_predict),
        .fetch_outstanding (fetch_outstanding),
        .flush             (flush),
        .deq_valid         (deq_valid),
        .deq_ready         (deq_ready),
        .deq_pc            (deq_pc),
        .deq_instr         (deq_instr),
        .deq_predict       (deq_predict),
        .count             (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [38:0] predict_of(input logic [31:0] pc);
        return {pc[4], pc[9:4], pc + 32'h0000_1000};
    endfunction

    function automatic vec_t makeVec(input logic ev, input logic [31:0] pc, input logic dr,
                                     input logic er, input logic dv, input logic [2:0] cnt,
                                     input logic [31:0] epc);
        vec_t v;
        v.ev = ev; v.pc = pc; v.dr = dr; v.fl = 1'b0; v.fo = 1'b0;
        v.exp_ready = er; v.exp_valid = dv; v.exp_count = cnt; v.exp_pc = epc;
        return v;
    endfunction

    task automatic applyStimulus(input logic ev, input logic [31:0] pc, input logic dr,
                                 input logic fl, input logic fo);
        enq_valid         = ev;
        enq_pc            = pc;
        enq_instr         = instr_of(pc);
        enq_predict       = predict_of(pc);
        deq_ready         = dr;
        flush             = fl;
        fetch_outstanding = fo;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
        advance();
    endtask

    task automatic checkHead(input string name, input logic [2:0] cnt, input logic [31:0] pc);
        checkOutput({name, "_count"}, 64'(count), 64'(cnt));
        checkOutput({name, "_valid"}, 64'(deq_valid), 64'(1));
        checkOutput({name, "_pc"}, 64'(deq_pc), 64'(pc));
        checkOutput({name, "_predict"}, 64'(deq_predict), 64'(predict_of(pc)));
    endtask

    task automatic checkCleared(input string name);
        checkOutput({name, "_count"}, 64'(count), 64'(0));
        checkOutput({name, "_valid"}, 64'(deq_valid), 64'(0));
        checkOutput({name, "_pc"}, 64'(deq_pc), 64'(0));
        checkOutput({name, "_ready"}, 64'(enq_ready), 64'(1));
    endtask

    task automatic modelStep(input logic ev, input logic [31:0] pc, input logic dr,
                             input logic fl, input logic fo);
        entry_t e;
        bit acc;
        bit pop;
        if (fl) begin
            model_q.delete();
            model_drop = model_drop || (fo && !ev);
        end else begin
            acc = ev && (model_q.size() != DEPTH) && !model_drop;
            pop = dr && (model_q.size() != 0);
            if (model_drop && ev) model_drop = 1'b0;
            if (pop) void'(model_q.pop_front());
            if (acc) begin
                e.pc = pc; e.instr = instr_of(pc); e.predict = predict_of(pc);
                model_q.push_back(e);
            end
        end
    endtask

    initial begin
        logic ev, dr, fl, fo;
        logic [31:0] pc;
        reset_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #3;
        checkCleared("reset");
        checkOutput("reset_instr", 64'(deq_instr), 64'(0));
        checkOutput("reset_predict", 64'(deq_predict), 64'(0));
        doReset();

        // Fill four, refuse a fifth, then drain in order.
        vecs[0] = makeVec(1'b1, 32'h00, 1'b0, 1'b1, 1'b0, 3'd0, 32'h00);
        vecs[1] = makeVec(1'b1, 32'h04, 1'b0, 1'b1, 1'b1, 3'd1, 32'h00);
        vecs[2] = makeVec(1'b1, 32'h08, 1'b0, 1'b1, 1'b1, 3'd2, 32'h00);
        vecs[3] = makeVec(1'b1, 32'h0C, 1'b0, 1'b1, 1'b1, 3'd3, 32'h00);
        vecs[4] = makeVec(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 3'd4, 32'h00);
        vecs[5] = makeVec(1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 3'd4, 32'h00);
        vecs[6] = makeVec(1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3'd3, 32'h04);
        vecs[7] = makeVec(1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3'd2, 32'h08);
        vecs[8] = makeVec(1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3'd1, 32'h0C);
        vecs[9] = makeVec(1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 3'd0, 32'h00);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].ev, vecs[i].pc, vecs[i].dr, vecs[i].fl, vecs[i].fo);
            @(negedge clk);
            checkOutput($sformatf("fill_ready_%0d", i), 64'(enq_ready), 64'(vecs[i].exp_ready));
            checkOutput($sformatf("fill_valid_%0d", i), 64'(deq_valid), 64'(vecs[i].exp_valid));
            checkOutput($sformatf("fill_count_%0d", i), 64'(count), 64'(vecs[i].exp_count));
            if (vecs[i].exp_valid)
                checkOutput($sformatf("fill_pc_%0d", i), 64'(deq_pc), 64'(vecs[i].exp_pc));
            advance();
        end

        // Streaming: one in, one out every cycle; pointers wrap three times.
        for (int k = 0; k <= 12; k++) begin
            applyStimulus(k < 12, 32'h100 + 32'(4 * k), 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            if (k == 0) checkOutput("stream_first_valid", 64'(deq_valid), 64'(0));
            else checkHead($sformatf("stream_%0d", k), 3'd1, 32'h100 + 32'(4 * (k - 1)));
            advance();
        end
        @(negedge clk);
        checkOutput("stream_end_count", 64'(count), 64'(0));
        advance();

        // Flush with a full queue while decode is ready.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h300 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
            advance();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("flushfull_valid", 64'(deq_valid), 64'(0));
        checkOutput("flushfull_count", 64'(count), 64'(4));
        checkOutput("flushfull_ready", 64'(enq_ready), 64'(0));
        advance();
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("flushfull_after_count", 64'(count), 64'(0));
        checkOutput("flushfull_after_valid", 64'(deq_valid), 64'(0));
        advance();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkHead("flushfull_new", 3'd1, 32'h200);
        advance();

        // Stale response after a flush with a read in flight.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        advance();
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stale_ready", 64'(enq_ready), 64'(1));
        checkOutput("stale_count", 64'(count), 64'(0));
        advance();
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stale_dropped_count", 64'(count), 64'(0));
        checkOutput("stale_dropped_valid", 64'(deq_valid), 64'(0));
        advance();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkHead("stale_target", 3'd1, 32'h80);
        advance();
        @(negedge clk);
        checkOutput("stale_empty", 64'(count), 64'(0));
        advance();

        // Flush coinciding with the in-flight response.
        applyStimulus(1'b1, 32'h44, 1'b0, 1'b1, 1'b1);
        advance();
        applyStimulus(1'b1, 32'h90, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("coincide_count", 64'(count), 64'(0));
        advance();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkHead("coincide_next", 3'd1, 32'h90);
        advance();

        // Asynchronous reset mid-cycle, first with occupancy, then while dropping.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h600 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
            advance();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("areset_pre_count", 64'(count), 64'(3));
        #2 reset_n = 1'b0;
        #1 checkCleared("areset_full");
        @(negedge clk);
        reset_n = 1'b1;
        advance();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        advance();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1 checkCleared("areset_drop");
        @(negedge clk);
        reset_n = 1'b1;
        advance();
        applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 1'b0);
        advance();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkHead("areset_run", 3'd1, 32'h60);
        advance();

        // Randomized traffic against the queue model.
        doReset();
        model_q.delete();
        model_drop = 1'b0;
        for (int c = 0; c < 400; c++) begin
            ev = ($urandom_range(3) != 0);
            pc = $urandom & 32'hFFFF_FFFC;
            dr = 1'($urandom_range(1));
            fl = ($urandom_range(15) == 0);
            fo = 1'($urandom_range(1));
            applyStimulus(ev, pc, dr, fl, fo);
            @(negedge clk);
            checkOutput("rnd_ready", 64'(enq_ready), 64'(model_q.size() != DEPTH));
            checkOutput("rnd_valid", 64'(deq_valid), 64'((model_q.size() != 0) && !fl));
            checkOutput("rnd_count", 64'(count), 64'(model_q.size()));
            checkOutput("rnd_count_bound", 64'(count <= 3'(DEPTH)), 64'(1));
            if ((model_q.size() != 0) && !fl) begin
                checkOutput("rnd_pc", 64'(deq_pc), 64'(model_q[0].pc));
                checkOutput("rnd_instr", 64'(deq_instr), 64'(model_q[0].instr));
                checkOutput("rnd_predict", 64'(deq_predict), 64'(model_q[0].predict));
            end
            @(posedge clk);
            modelStep(ev, pc, dr, fl, fo);
            #1;
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
